mdc_commutator: RTL and testbench

MDC_COMMUTATOR -- requirements
Module: mdc_commutator

---
 rtl/mdc_commutator.sv | 126 ++++++++++++
 tb/tb_mdc_commutator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdc_commutator.sv
// mdc_commutator: multi-path delay commutator between two NWC butterfly stages.
// It reorders a pair stream (BU_a, BU_b) so that each output pair carries two
// same-stream elements DELAY beats apart.
// Data width comes from the project-wide `D_width macro, normally supplied by
// define.svh. The fallback below lets this file elaborate on its own.
// Optional feature: define MDC_SYNC_CLR_EN to add the sync_clr input, which
// restarts the beat/fill sequencing without flushing the delay lines.
`ifndef D_width
`define D_width 16
`endif

module mdc_commutator #(
  parameter int unsigned DELAY = 4
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MDC_SYNC_CLR_EN
  input  logic                sync_clr,
`endif
  input  logic                in_valid,
  input  logic [`D_width-1:0] in_a,
  input  logic [`D_width-1:0] in_b,
  output logic                out_valid,
  output logic [`D_width-1:0] out_a,
  output logic [`D_width-1:0] out_b
);

  localparam int unsigned W  = `D_width;
  // With DELAY=1 the beat counter is a single bit held at zero.
  localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned FW = $clog2(DELAY + 1);

  logic          run;
  logic          clr;
  logic          beat;
  logic          wrap;
  logic [CW-1:0] cnt;
  logic          sel;
  logic [FW-1:0] fill;
  logic [W-1:0]  u_line [DELAY];
  logic [W-1:0]  l_line [DELAY];
  logic [W-1:0]  u_out;
  logic [W-1:0]  l_out;
  logic [W-1:0]  s0;
  logic [W-1:0]  s1;

`ifdef MDC_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  // A beat is accepted only after the reset release has been registered
  // and never on a clearing edge.
  assign beat  = run & in_valid & ~clr;
  assign wrap  = (DELAY == 1) ? 1'b1 : (cnt == CW'(DELAY - 1));
  assign u_out = u_line[DELAY-1];
  assign l_out = l_line[DELAY-1];

  // Release flag: the edge that samples rst high does not take a beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Switch between the delayed upper stream and the live lower stream.
  always_comb begin
    s0 = u_out;
    s1 = in_b;
    if (sel) begin
      s0 = in_b;
      s1 = u_out;
    end
  end

  // Upper and lower delay lines shift only on accepted beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        u_line[i] <= '0;
        l_line[i] <= '0;
      end
    end else if (beat) begin
      u_line[0] <= in_a;
      l_line[0] <= s1;
      for (int unsigned i = 1; i < DELAY; i++) begin
        u_line[i] <= u_line[i-1];
        l_line[i] <= l_line[i-1];
      end
    end
  end

  // Beat counter, switch select and saturating fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sel  <= 1'b0;
      fill <= '0;
    end else if (clr) begin
      cnt  <= '0;
      sel  <= 1'b0;
      fill <= '0;
    end else if (beat) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) sel <= ~sel;
      if (fill != FW'(DELAY)) fill <= fill + 1'b1;
    end
  end

  // Registered output pair; data holds between beats, valid pulses per beat
  // once the lines have filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (beat) begin
      out_valid <= (fill == FW'(DELAY));
      out_a     <= l_out;
      out_b     <= s0;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdc_commutator.sv
// Self-checking bench for mdc_commutator: a DELAY=2 and a DELAY=1 instance
// share clock, reset and in_valid. A beat-indexed history model predicts each
// output pair; directed literal expectations pin the model.
`ifndef D_width
`define D_width 16
`endif

module tb_mdc_commutator;
  localparam int W = `D_width;
  localparam int unsigned DD [2] = '{2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sclr;
  logic         iv;
  logic [W-1:0] ia [2];
  logic [W-1:0] ib [2];
  logic         ov [2];
  logic [W-1:0] oa [2];
  logic [W-1:0] ob [2];

  int errors = 0;
  int checks = 0;

  mdc_commutator #(.DELAY(2)) u_d2 (
    .clk(clk), .rst(rst),
`ifdef MDC_SYNC_CLR_EN
    .sync_clr(sclr),
`endif
    .in_valid(iv), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_a(oa[0]), .out_b(ob[0])
  );

  mdc_commutator #(.DELAY(1)) u_d1 (
    .clk(clk), .rst(rst),
`ifdef MDC_SYNC_CLR_EN
    .sync_clr(sclr),
`endif
    .in_valid(iv), .in_a(ia[1]), .in_b(ib[1]),
    .out_valid(ov[1]), .out_a(oa[1]), .out_b(ob[1])
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember every accepted beat by index since the last restart.
  // Beat k (k >= D) lies in block k/D; odd blocks pair lower-stream elements
  // (b[k-D], b[k]), even blocks pair upper-stream elements (a[k-2D], a[k-D]).
  logic [W-1:0] ha [2][256];
  logic [W-1:0] hb [2][256];
  int unsigned  k  [2];
  logic         rel;
  logic         ev [2];
  logic [W-1:0] ea [2];
  logic [W-1:0] eb [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        k[i] <= 0; ev[i] <= 1'b0; ea[i] <= '0; eb[i] <= '0;
      end
    end else if (!rel) begin
      rel <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sclr) begin
          k[i] <= 0; ev[i] <= 1'b0;
        end else if (iv) begin
          ha[i][k[i]] <= ia[i];
          hb[i][k[i]] <= ib[i];
          k[i] <= k[i] + 1;
          if (k[i] >= DD[i]) begin
            ev[i] <= 1'b1;
            if (((k[i] / DD[i]) % 2) == 1) begin
              ea[i] <= hb[i][k[i]-DD[i]];
              eb[i] <= ib[i];
            end else begin
              ea[i] <= ha[i][k[i]-2*DD[i]];
              eb[i] <= ha[i][k[i]-DD[i]];
            end
          end else begin
            ev[i] <= 1'b0;
          end
        end else begin
          ev[i] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_valid_d%0d", DD[i]), W'(ov[i]), W'(ev[i]));
      chk($sformatf("model_a_d%0d", DD[i]), oa[i], ea[i]);
      chk($sformatf("model_b_d%0d", DD[i]), ob[i], eb[i]);
    end
  end

  // One cycle of stimulus; returns 2 time units after the sampling edge.
  task automatic step(input logic v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input logic [W-1:0] a1, input logic [W-1:0] b1);
    iv = v; ia[0] = a0; ib[0] = b0; ia[1] = a1; ib[1] = b1;
    @(posedge clk);
    #2;
  endtask

  task automatic junk();
    step(1'b1, W'('hEEE), W'('hDDD), W'('hCCC), W'('hBBB));
  endtask

  task automatic lit_pair(input int i, input int t, input logic [W-1:0] a, input logic [W-1:0] b);
    chk($sformatf("lit_valid_d%0d_t%0d", DD[i], t), W'(ov[i]), W'(1));
    chk($sformatf("lit_a_d%0d_t%0d", DD[i], t), oa[i], a);
    chk($sformatf("lit_b_d%0d_t%0d", DD[i], t), ob[i], b);
  endtask

  task automatic lit_idle(input int i, input int t);
    chk($sformatf("lit_novalid_d%0d_t%0d", DD[i], t), W'(ov[i]), W'(0));
  endtask

  // Hand-computed pairs for beat t of the restarted stream.
  task automatic lit(input int t);
    case (t)
      0: begin lit_idle(0, t); lit_idle(1, t); end
      1: begin lit_idle(0, t); lit_pair(1, t, W'('h100), W'('h101)); end
      2: begin lit_pair(0, t, W'('h20), W'('h22)); lit_pair(1, t, W'('h0), W'('h1)); end
      3: begin lit_pair(0, t, W'('h21), W'('h23)); lit_pair(1, t, W'('h102), W'('h103)); end
      4: lit_pair(0, t, W'('h10), W'('h12));
      5: lit_pair(0, t, W'('h11), W'('h13));
      6: lit_pair(0, t, W'('h24), W'('h26));
      default: ;
    endcase
  endtask

  task automatic beat(input int t);
    step(1'b1, W'('h10 + t), W'('h20 + t), W'(t), W'('h100 + t));
    lit(t);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid_d%0d", DD[i]), W'(ov[i]), W'(0));
      chk($sformatf("rst_a_d%0d", DD[i]), oa[i], '0);
      chk($sformatf("rst_b_d%0d", DD[i]), ob[i], '0);
    end
    step(1'b1, W'('hEEE), W'('hDDD), W'('hCCC), W'('hBBB));
    step(1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    junk();
  endtask

  initial begin
    rst = 1'b0; sclr = 1'b0; iv = 1'b0;
    ia[0] = '0; ib[0] = '0; ia[1] = '0; ib[1] = '0;
    #2;
    do_reset();

    // Continuous stream.
    for (int t = 0; t < 10; t++) beat(t);

    // Gap of three idle cycles between beats 3 and 4, then reset after beat 4.
    do_reset();
    for (int t = 0; t < 4; t++) beat(t);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, W'('hEEE), W'('hDDD), W'('hCCC), W'('hBBB));
      lit_idle(0, 100 + g);
      lit_idle(1, 100 + g);
      chk("gap_hold_a_d2", oa[0], W'('h21));
      chk("gap_hold_b_d2", ob[0], W'('h23));
      chk("gap_hold_a_d1", oa[1], W'('h102));
      chk("gap_hold_b_d1", ob[1], W'('h103));
    end
    beat(4);
    do_reset();
    for (int t = 0; t < 7; t++) beat(t);

`ifdef MDC_SYNC_CLR_EN
    // Sync clear with a concurrent beat, then restart of the stream.
    sclr = 1'b1;
    junk();
    sclr = 1'b0;
    lit_idle(0, 200);
    lit_idle(1, 200);
    for (int t = 0; t < 5; t++) beat(t);
`endif

    step(1'b0, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
